// File: rtl/glupost_mode_ctrl_pkg.sv
// glupost_mode_ctrl_pkg: state encodings, btn2 command codes and BCD helpers shared by the mode controller.
package glupost_mode_ctrl_pkg;
    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_TIMER  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_CLR = 2'd1, CMD_LOAD = 2'd2} cmd_t;

    function automatic cmd_t decode_cmd(input logic [1:0] code);
        return code[1] ? CMD_LOAD : (code[0] ? CMD_CLR : CMD_NOP);
    endfunction

    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction
endpackage

// File: rtl/glupost_mode_ctrl_edge_det.sv
// glupost_mode_ctrl_edge_det: rising-edge detector whose history resets high, so a held button needs release first.
module glupost_mode_ctrl_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] hist;

    always_ff @(posedge clk) begin
        if (sync_reset) hist <= '1;
        else hist <= level;
    end

    assign rise = level & ~hist;
endmodule

// File: rtl/glupost_mode_ctrl.sv
// glupost_mode_ctrl: turns board buttons into one-cycle load/inc/dec commands for the BCD datapath
// and runs a prescaled countdown timer that flags expiry on led0.
module glupost_mode_ctrl
    import glupost_mode_ctrl_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int VAL_W    = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [6:0]       sw,
    input  logic             btn2,
    input  logic             btn1,
    input  logic             btn0,
    input  logic             cnt_zero,
    output logic             cnt_load,
    output logic [VAL_W-1:0] cnt_load_value,
    output logic             cnt_inc,
    output logic             cnt_dec,
    output logic             mode_timer,
    output logic             led0
);
    localparam int PW = $clog2(PRESCALE);

    logic [1:0]       state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic             e0, e1, e2, tick, run_cmd, load_n, inc_n, dec_n, sw_unused;
    logic [VAL_W-1:0] val_n;
    cmd_t             cmd;

    glupost_mode_ctrl_edge_det u_ed0 (.clk(clk), .sync_reset(sync_reset), .level(btn0), .rise(e0));
    glupost_mode_ctrl_edge_det u_ed1 (.clk(clk), .sync_reset(sync_reset), .level(btn1), .rise(e1));
    glupost_mode_ctrl_edge_det u_ed2 (.clk(clk), .sync_reset(sync_reset), .level(btn2), .rise(e2));

    assign sw_unused = sw[4];
    assign cmd       = decode_cmd(sw[6:5]);
    assign tick      = presc == PW'(PRESCALE - 1);

    // Edge priority btn0 > btn2 > btn1; the prescaler only runs while in TIMER and is zero elsewhere.
    always_comb begin
        state_n = state;
        presc_n = '0;
        run_cmd = 1'b0;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        case (state)
            ST_MANUAL: begin
                if (e0) state_n = cnt_zero ? ST_MANUAL : ST_TIMER;
                else begin
                    run_cmd = e2;
                    inc_n   = e1 & ~e2;
                end
            end
            ST_TIMER: begin
                if (e0) state_n = ST_MANUAL;
                else if (tick) begin
                    state_n = cnt_zero ? ST_DONE : ST_TIMER;
                    dec_n   = ~cnt_zero;
                end
                else presc_n = presc + PW'(1);
            end
            ST_DONE: begin
                state_n = (e0 | e1 | e2) ? ST_MANUAL : ST_DONE;
                run_cmd = e2 & ~e0;
            end
            default: state_n = ST_MANUAL;
        endcase
    end

    assign load_n = run_cmd && (cmd != CMD_NOP);
    assign val_n  = (run_cmd && cmd == CMD_LOAD) ? VAL_W'(clamp_bcd(sw[3:0])) : '0;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state          <= ST_MANUAL;
            presc          <= '0;
            cnt_load       <= 1'b0;
            cnt_load_value <= '0;
            cnt_inc        <= 1'b0;
            cnt_dec        <= 1'b0;
        end
        else begin
            state          <= state_n;
            presc          <= presc_n;
            cnt_load       <= load_n;
            cnt_load_value <= val_n;
            cnt_inc        <= inc_n;
            cnt_dec        <= dec_n;
        end
    end

    assign mode_timer = state == ST_TIMER;
    assign led0       = state == ST_DONE;
endmodule

// File: tb/tb_glupost_mode_ctrl.sv
// tb_glupost_mode_ctrl: scoreboard bench; an event-level model predicts pulses and modes, a monitor checks them.
module tb_glupost_mode_ctrl;
    localparam int PRESCALE = 4;
    localparam int MAN = 0, TMR = 1, DN = 2;

    typedef struct {int at; int kind; int val;} pulse_t;
    typedef struct {int mt; int led;} mode_t;

    logic       clk, sync_reset, btn0, btn1, btn2, cnt_zero;
    logic [6:0] sw;
    logic       cnt_load, cnt_inc, cnt_dec, mode_timer, led0;
    logic [3:0] cnt_load_value;

    pulse_t pq[$];
    mode_t  mq[$];
    int n_chk = 0, n_fail = 0, n_edge = 0;
    int mmode = MAN, age = 0, mcnt = 0, pend_k = 0, pend_v = 0;
    logic [2:0] hist = 3'b111;
    int dut_cnt = 0;

    glupost_mode_ctrl #(.PRESCALE(PRESCALE), .VAL_W(4)) dut (
        .clk(clk), .sync_reset(sync_reset), .sw(sw), .btn2(btn2), .btn1(btn1), .btn0(btn0),
        .cnt_zero(cnt_zero), .cnt_load(cnt_load), .cnt_load_value(cnt_load_value),
        .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .mode_timer(mode_timer), .led0(led0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side stand-in for glupost_bcd_cnt, driven purely by the DUT's pulses.
    always @(posedge clk) begin
        if (cnt_load === 1'b1) dut_cnt <= int'(cnt_load_value);
        else if (cnt_inc === 1'b1) dut_cnt <= (dut_cnt + 1) % 10;
        else if (cnt_dec === 1'b1) dut_cnt <= (dut_cnt == 0) ? 9 : dut_cnt - 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    // One clock: predict this edge's effect at the level of buttons/modes/ages, then advance.
    task automatic tick();
        logic [2:0] b, e;
        int k, v;
        cnt_zero = (mcnt == 0);
        b = {btn2, btn1, btn0};
        k = 0;
        v = 0;
        if (sync_reset) begin
            mmode = MAN;
            hist = 3'b111;
        end else begin
            e = b & ~hist;
            hist = b;
            if (mmode == MAN) begin
                if (e[0]) begin
                    if (mcnt != 0) begin mmode = TMR; age = 0; end
                end else if (e[2]) begin
                    if (sw[6] | sw[5]) begin k = 1; v = sw[6] ? ((sw[3:0] > 9) ? 9 : int'(sw[3:0])) : 0; end
                end else if (e[1]) k = 2;
            end else if (mmode == TMR) begin
                if (e[0]) mmode = MAN;
                else begin
                    age++;
                    if (age % PRESCALE == 0) begin
                        if (mcnt == 0) mmode = DN; else k = 3;
                    end
                end
            end else if (e != 3'b000) begin
                mmode = MAN;
                if (e[2] && !e[0] && (sw[6] | sw[5])) begin
                    k = 1;
                    v = sw[6] ? ((sw[3:0] > 9) ? 9 : int'(sw[3:0])) : 0;
                end
            end
        end
        if (pend_k == 1) mcnt = pend_v;
        else if (pend_k == 2) mcnt = (mcnt + 1) % 10;
        else if (pend_k == 3) mcnt = (mcnt == 0) ? 9 : mcnt - 1;
        pend_k = k;
        pend_v = v;
        if (k != 0) pq.push_back('{n_edge + 1, k, v});
        mq.push_back('{int'(mmode == TMR), int'(mmode == DN)});
        @(posedge clk);
        n_edge++;
        #1;
    endtask

    task automatic press(input int i);
        if (i == 0) btn0 = 1'b1; else if (i == 1) btn1 = 1'b1; else btn2 = 1'b1;
        tick();
        btn0 = 1'b0;
        btn1 = 1'b0;
        btn2 = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        pulse_t p;
        mode_t m;
        int kind;
        if (n_edge > 0) begin
            if (mq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mode_queue: got empty expected an entry (edge %0d)", n_edge);
            end else begin
                m = mq.pop_front();
                chk("mode_timer", int'(mode_timer), m.mt);
                chk("led0", int'(led0), m.led);
            end
            chk("pulse_exclusive", int'(cnt_load) + int'(cnt_inc) + int'(cnt_dec) <= 1, 1);
            while (pq.size() > 0 && pq[0].at < n_edge) begin
                p = pq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_pulse: got none expected kind %0d at edge %0d", p.kind, p.at);
            end
            if (cnt_load | cnt_inc | cnt_dec) begin
                kind = cnt_load ? 1 : (cnt_inc ? 2 : 3);
                if (pq.size() > 0 && pq[0].at == n_edge) begin
                    p = pq.pop_front();
                    chk("pulse_kind", kind, p.kind);
                    if (kind == 1) chk("load_value", int'(cnt_load_value), p.val);
                end else chk("unexpected_pulse", kind, 0);
            end
        end
    end

    initial begin
        sync_reset = 1'b1;
        btn0 = 1'b0;
        btn1 = 1'b1;
        btn2 = 1'b0;
        sw = 7'd0;
        cnt_zero = 1'b1;
        idle(3);
        sync_reset = 1'b0;
        idle(3);
        chk("held_btn1_no_inc", dut_cnt, 0);
        btn1 = 1'b0;
        tick();
        press(1);
        tick();
        chk("inc_once", dut_cnt, 1);

        sw = 7'b110_0111;
        press(2);
        tick();
        chk("load7", dut_cnt, 7);
        sw = 7'b100_1100;
        press(2);
        tick();
        chk("load_clamp9", dut_cnt, 9);

        sw = 7'b100_0011;
        press(2);
        tick();
        press(0);
        chk("timer_entered", int'(mode_timer), 1);
        idle(16);
        chk("timer_expired_led0", int'(led0), 1);
        chk("timer_count0", dut_cnt, 0);

        sw = 7'b010_0000;
        press(2);
        chk("done_exit_led0", int'(led0), 0);
        chk("done_exit_manual", int'(mode_timer), 0);

        press(0);
        idle(2);
        chk("zero_no_timer", int'(mode_timer), 0);
        sw = 7'b100_0010;
        press(2);
        tick();
        btn0 = 1'b1;
        btn1 = 1'b1;
        tick();
        btn0 = 1'b0;
        btn1 = 1'b0;
        tick();
        chk("btn0_btn1_timer", int'(mode_timer), 1);
        chk("btn0_btn1_no_inc", dut_cnt, 2);
        press(0);

        sw = 7'b100_0101;
        press(2);
        tick();
        press(0);
        idle(5);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk("reset_mid_timer", int'(mode_timer), 0);
        idle(8);
        chk("reset_count_held", dut_cnt, mcnt);
        press(0);
        idle(5);
        press(0);
        idle(8);
        chk("abort_manual", int'(mode_timer), 0);
        chk("abort_count_held", dut_cnt, mcnt);

        for (int i = 0; i < 3000; i++) begin
            btn0 = ($urandom_range(0, 39) == 0);
            btn1 = ($urandom_range(0, 7) == 0);
            btn2 = ($urandom_range(0, 7) == 0);
            sw = 7'($urandom_range(0, 127));
            sync_reset = ($urandom_range(0, 299) == 0);
            tick();
            chk("count_track", dut_cnt, mcnt);
        end

        sync_reset = 1'b0;
        btn0 = 1'b0;
        btn1 = 1'b0;
        btn2 = 1'b0;
        idle(3);
        chk("leftover_pulses", pq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
